// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Hits are served with zero stall. A miss stalls the CPU, writes back a dirty victim
// if there is one, refills the one-word line and then replays the access as a hit.
// Optional hit/miss statistics are built when DCACHE_STATS_EN is defined.
module dcache_ctrl #(
    parameter int NUM_LINES = 64,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - 2 - IDX_W;

    typedef enum logic [2:0] {
        IDLE,
        WB_ISSUE,
        WB_WAIT,
        FILL_ISSUE,
        FILL_WAIT
    } state_t;

    state_t state, state_nxt;

    logic [31:0]          data_arr [NUM_LINES];
    logic [TAG_W-1:0]     tag_arr  [NUM_LINES];
    logic [NUM_LINES-1:0] valid_arr;
    logic [NUM_LINES-1:0] dirty_arr;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] req_tag;
    logic             req;
    logic             hit;
    logic             fill_done;
    logic             unused_addr_bits;

    assign idx              = cpu_addr[2+IDX_W-1:2];
    assign req_tag          = cpu_addr[ADDR_W-1:2+IDX_W];
    assign req              = cpu_read | cpu_write;
    assign hit              = valid_arr[idx] && (tag_arr[idx] == req_tag);
    assign fill_done        = (state == FILL_WAIT) && mem_ready;
    assign unused_addr_bits = &{1'b0, cpu_addr[1:0]};

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode plus memory-side outputs, which depend on the state register only
    // (address/data come from the arrays and the held CPU request, so they stay stable in WAIT).
    always_comb begin
        state_nxt = state;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                if (req && !hit)
                    state_nxt = (valid_arr[idx] && dirty_arr[idx]) ? WB_ISSUE : FILL_ISSUE;
            end
            WB_ISSUE: begin
                mem_write = 1'b1;
                mem_addr  = {tag_arr[idx], idx, 2'b00};
                mem_wdata = data_arr[idx];
                state_nxt = WB_WAIT;
            end
            WB_WAIT: begin
                mem_addr  = {tag_arr[idx], idx, 2'b00};
                mem_wdata = data_arr[idx];
                if (mem_ready) state_nxt = FILL_ISSUE;
            end
            FILL_ISSUE: begin
                mem_read  = 1'b1;
                mem_addr  = {req_tag, idx, 2'b00};
                state_nxt = FILL_WAIT;
            end
            FILL_WAIT: begin
                mem_addr = {req_tag, idx, 2'b00};
                if (mem_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // CPU-side outputs: load data straight from the array, stall while busy or missing.
    always_comb begin
        cpu_rdata = data_arr[idx];
        cpu_stall = req && ((state != IDLE) || !hit);
    end

    // Valid/dirty bits: refill makes a line valid and clean, a store hit makes it dirty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_arr <= '0;
            dirty_arr <= '0;
        end else if (fill_done) begin
            valid_arr[idx] <= 1'b1;
            dirty_arr[idx] <= 1'b0;
        end else if ((state == IDLE) && cpu_write && hit) begin
            dirty_arr[idx] <= 1'b1;
        end
    end

    // Data and tag arrays are never reset; valid bits qualify their contents.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            data_arr[idx] <= mem_rdata;
            tag_arr[idx]  <= req_tag;
        end else if ((state == IDLE) && cpu_write && hit) begin
            data_arr[idx] <= cpu_wdata;
        end
    end

`ifdef DCACHE_STATS_EN
    logic        replay;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    // Count misses on detection and hits only for first-time accesses, not refill replays.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            replay   <= 1'b0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            replay <= fill_done;
            if ((state == IDLE) && req) begin
                if (!hit)        miss_cnt <= miss_cnt + 32'd1;
                else if (!replay) hit_cnt <= hit_cnt + 32'd1;
            end
        end
    end

    assign hit_count  = hit_cnt;
    assign miss_count = miss_cnt;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios followed by random traffic,
// compared against a transaction-level cache model and a latency-configurable memory.
module tb_dcache_ctrl;
    localparam int NL = 64;
    localparam int AW = 32;
    localparam int IW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cpu_read, cpu_write;
    logic [AW-1:0] cpu_addr;
    logic [31:0]   cpu_wdata, cpu_rdata;
    logic          cpu_stall;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic          mem_ready;
    logic [31:0]   hit_count, miss_count;

    dcache_ctrl #(.NUM_LINES(NL), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
    } mev_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          lat      = 0;
    logic [31:0] exp_rd [$];
    mev_t        exp_mem [$];
    logic [31:0] mem_img [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    logic [31:0] m_data  [NL];
    int unsigned m_tag   [NL];
    bit          m_valid [NL];
    bit          m_dirty [NL];
    int          m_hit, m_miss;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_val(a);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NL; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        m_hit  = 0;
        m_miss = 0;
    endtask

    // Transaction-level cache: decides hit/miss, queues expected memory traffic and load data.
    task automatic model_access(input bit rd, input bit wr, input logic [31:0] a,
                                input logic [31:0] wd, output int stall);
        int unsigned i, t;
        logic [31:0] base, va;
        mev_t ev;
        i    = (a / 4) % NL;
        t    = a / (4 * NL);
        base = a & ~32'd3;
        if (m_valid[i] && m_tag[i] == t) begin
            stall = 0;
            m_hit++;
        end else begin
            m_miss++;
            stall = 3 + lat;
            if (m_valid[i] && m_dirty[i]) begin
                va = (m_tag[i] * NL + i) * 4;
                ev.is_wr = 1'b1; ev.addr = va; ev.data = m_data[i];
                exp_mem.push_back(ev);
                ref_mem[va] = m_data[i];
                stall += 2 + lat;
            end
            ev.is_wr = 1'b0; ev.addr = base; ev.data = 32'd0;
            exp_mem.push_back(ev);
            m_data[i]  = ref_rd(base);
            m_tag[i]   = t;
            m_valid[i] = 1'b1;
            m_dirty[i] = 1'b0;
        end
        if (wr) begin
            m_data[i]  = wd;
            m_dirty[i] = 1'b1;
        end else if (rd) begin
            exp_rd.push_back(m_data[i]);
        end
    endtask

    // Issue one CPU access at posedge+1, hold it while stalled, release after it completes.
    task automatic do_access(input bit rd, input bit wr, input logic [31:0] a,
                             input logic [31:0] wd, input string nm);
        int exp_st, cyc;
        model_access(rd, wr, a, wd, exp_st);
        cpu_read = rd; cpu_write = wr; cpu_addr = a; cpu_wdata = wd;
        cyc = 0;
        @(negedge clk);
        while (cpu_stall && cyc < 300) begin
            cyc++;
            @(negedge clk);
        end
        chk(nm, cyc, exp_st);
        @(posedge clk); #1;
        cpu_read = 1'b0; cpu_write = 1'b0;
    endtask

    task automatic chk_counters(input string nm);
`ifdef DCACHE_STATS_EN
        chk({nm, "_hits"}, hit_count, m_hit);
        chk({nm, "_misses"}, miss_count, m_miss);
`else
        chk({nm, "_hits"}, hit_count, 32'd0);
        chk({nm, "_misses"}, miss_count, 32'd0);
`endif
    endtask

    // Load-data monitor: every completed load pops its expected word.
    always @(negedge clk) begin
        if (rst_n && cpu_read && !cpu_write && !cpu_stall) begin
            if (exp_rd.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL rdata_unexpected: load completed with %h, none outstanding", cpu_rdata);
            end else begin
                chk("cpu_rdata", cpu_rdata, exp_rd.pop_front());
            end
        end
    end

    // Memory-pulse monitor: every pulse must match the next expected transaction.
    always @(negedge clk) begin
        mev_t e;
        if (rst_n && (mem_read || mem_write)) begin
            chk("mem_pulse_exclusive", 32'(mem_read & mem_write), 32'd0);
            if (exp_mem.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL mem_unexpected: rd=%0b wr=%0b addr=%h, none outstanding",
                         mem_read, mem_write, mem_addr);
            end else begin
                e = exp_mem.pop_front();
                chk("mem_kind_is_write", 32'(mem_write), 32'(e.is_wr));
                chk("mem_addr", mem_addr, e.addr);
                if (e.is_wr) chk("mem_wdata", mem_wdata, e.data);
            end
        end
    end

    // Main memory: answers each pulse with mem_ready after 1+lat cycles.
    initial begin
        logic [31:0] a, w;
        bit          isw, aborted;
        mem_ready = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (rst_n && (mem_read || mem_write)) begin
                a = mem_addr; w = mem_wdata; isw = mem_write; aborted = 1'b0;
                for (int k = 0; k < lat; k++) begin
                    @(posedge clk); #1;
                    if (!rst_n) begin aborted = 1'b1; break; end
                end
                if (!aborted) begin
                    @(posedge clk); #1;
                    if (isw) mem_img[a] = w;
                    else     mem_rdata = mem_img.exists(a) ? mem_img[a] : init_val(a);
                    mem_ready = 1'b1;
                    @(negedge clk);
                    chk("mem_addr_held", mem_addr, a);
                    if (isw) chk("mem_wdata_held", mem_wdata, w);
                    @(posedge clk); #1;
                    mem_ready = 1'b0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int st;
        rst_n = 1'b0;
        cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("reset_stall", 32'(cpu_stall), 32'd0);
        chk("reset_mem_read", 32'(mem_read), 32'd0);
        chk("reset_mem_write", 32'(mem_write), 32'd0);
        chk_counters("reset");
        @(posedge clk); #1;

        // Clean miss, store hit, load hit, dirty conflict miss.
        do_access(1, 0, 32'h40, 32'h0, "stall_clean_miss_0x40");
        chk_counters("after_first_miss");
        do_access(0, 1, 32'h40, 32'hDEADBEEF, "stall_store_hit");
        do_access(1, 0, 32'h40, 32'h0, "stall_load_hit");
        chk_counters("after_hits");
        do_access(1, 0, 32'h140, 32'h0, "stall_dirty_miss_0x140");

        // Store miss then a conflicting miss writes the stored word back.
        do_access(0, 1, 32'h80, 32'hCAFE0080, "stall_store_miss_0x80");
        do_access(1, 0, 32'h180, 32'h0, "stall_conflict_0x180");
        do_access(1, 0, 32'h80, 32'h0, "stall_reload_0x80");
        chk_counters("after_conflicts");

        // Slow memory: WAIT state holds, only one pulse.
        lat = 10;
        do_access(1, 0, 32'h200, 32'h0, "stall_slow_memory");
        lat = 0;

        // Reset during FILL_WAIT aborts the refill and invalidates every line.
        lat = 10;
        model_access(1, 0, 32'h300, 32'h0, st);
        cpu_read = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h300;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_read && n < 20);
        chk("reset_test_fill_issued", 32'(mem_read), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midmiss_reset_mem_read", 32'(mem_read), 32'd0);
        chk("midmiss_reset_mem_write", 32'(mem_write), 32'd0);
        exp_rd.delete();
        model_clear();
        cpu_read = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        chk_counters("after_midmiss_reset");
        @(posedge clk); #1;
        do_access(1, 0, 32'h300, 32'h0, "stall_after_reset_0x300");
        do_access(1, 0, 32'h40, 32'h0, "stall_after_reset_0x40");

        // Random traffic over a small footprint to mix hits, clean and dirty misses.
        for (int k = 0; k < 300; k++) begin
            int unsigned op;
            logic [31:0] a;
            a   = (($urandom_range(0, 3) * NL + $urandom_range(0, 7)) * 4) + $urandom_range(0, 3);
            op  = $urandom_range(0, 7);
            lat = int'($urandom_range(0, 2));
            if (op < 4)      do_access(1, 0, a, 32'h0, "stall_rand_load");
            else if (op < 7) do_access(0, 1, a, $urandom, "stall_rand_store");
            else             do_access(1, 1, a, $urandom, "stall_rand_rdwr");
        end
        lat = 0;
        repeat (4) @(posedge clk);
        chk_counters("final");
        chk("rdata_queue_drained", exp_rd.size(), 32'd0);
        chk("mem_queue_drained", exp_mem.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
